// File: rtl/vga_pkg.sv
// Shared VGA constants, colour type and sprite FSM states.
// Timing constants match the 640x480 @ 60 Hz timing stage.
package vga_pkg;

    localparam int HPIXELS = 640;
    localparam int HFP     = 16;
    localparam int HPULSE  = 96;
    localparam int HBP     = 48;
    localparam int VPIXELS = 480;
    localparam int VFP     = 10;
    localparam int VPULSE  = 2;
    localparam int VBP     = 33;

    typedef logic [7:0] rgb332_t;

    typedef enum logic [1:0] {
        S_DISPLAY,
        S_UPDATE_X,
        S_UPDATE_Y
    } state_t;

    // -8 has no positive counterpart in 4 bits, so it is folded to -7.
    function automatic logic [3:0] clamp_vel(input logic [3:0] d);
        return (d == 4'b1000) ? 4'b1001 : d;
    endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// Combinational one-axis position step with bounce at 0 and LIMIT.
// Arithmetic is done at 11-bit signed width so underflow is visible.
module sprite_axis_step #(
    parameter int LIMIT = 608
) (
    input  logic        [9:0] i_pos,
    input  logic signed [3:0] i_d,
    output logic        [9:0] o_pos,
    output logic signed [3:0] o_d
);

    localparam logic signed [10:0] LIM = 11'(LIMIT);

    logic signed [10:0] w_n;

    assign w_n = $signed({1'b0, i_pos}) + $signed({{7{i_d[3]}}, i_d});

    always_comb begin
        o_pos = w_n[9:0];
        o_d   = i_d;
        if (w_n < 0) begin
            o_pos = 10'd0;
            o_d   = -i_d;
        end else if (w_n > LIM) begin
            o_pos = LIM[9:0];
            o_d   = -i_d;
        end
    end

endmodule

// File: rtl/bounce_sprite_gen.sv
// Bouncing solid sprite over a flat background, RGB332 output.
// Position updates once per frame during vertical blanking.
module bounce_sprite_gen
    import vga_pkg::*;
#(
    parameter int      SPRITE_W     = 32,
    parameter int      SPRITE_H     = 32,
    parameter int      INIT_X       = 100,
    parameter int      INIT_Y       = 80,
    parameter int      STEP         = 2,
    parameter rgb332_t BG_COLOR     = 8'h03,
    parameter rgb332_t SPRITE_COLOR = 8'hE0
) (
    input  logic       vgaclk,
    input  logic       rst,
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    input  logic       run,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_dx,
    input  logic [3:0] cmd_dy,
    input  logic [7:0] cmd_color,
    output logic       frame_tick,
    output logic [9:0] sprite_x,
    output logic [9:0] sprite_y,
    output logic [2:0] out_red,
    output logic [2:0] out_green,
    output logic [1:0] out_blue
);

    state_t             r_state;
    logic        [9:0]  r_x;
    logic        [9:0]  r_y;
    logic signed [3:0]  r_dx;
    logic signed [3:0]  r_dy;
    rgb332_t            r_color;
    logic               r_pend;
    logic signed [3:0]  r_pdx;
    logic signed [3:0]  r_pdy;
    rgb332_t            r_pcol;
    logic               r_tick;

    logic signed [3:0]  w_dx_use;
    logic        [9:0]  w_x_nxt;
    logic        [9:0]  w_y_nxt;
    logic signed [3:0]  w_dx_nxt;
    logic signed [3:0]  w_dy_nxt;
    logic               w_boundary;
    logic        [10:0] w_hc_ext;
    logic        [10:0] w_vc_ext;
    logic        [10:0] w_x_ext;
    logic        [10:0] w_y_ext;
    logic               w_in_sprite;
    rgb332_t            w_pix;

    // X steps with the freshly loaded dx when a command is consumed this frame.
    assign w_dx_use = r_pend ? r_pdx : r_dx;

    sprite_axis_step #(
        .LIMIT(HPIXELS - SPRITE_W)
    ) u_step_x (
        .i_pos(r_x),
        .i_d  (w_dx_use),
        .o_pos(w_x_nxt),
        .o_d  (w_dx_nxt)
    );

    sprite_axis_step #(
        .LIMIT(VPIXELS - SPRITE_H)
    ) u_step_y (
        .i_pos(r_y),
        .i_d  (r_dy),
        .o_pos(w_y_nxt),
        .o_d  (w_dy_nxt)
    );

    assign w_boundary = (hc == 10'd0) && (vc == 10'(VPIXELS));
    assign cmd_ready  = !r_pend && (r_state == S_DISPLAY) && !rst;

    always_ff @(posedge vgaclk) begin
        if (rst) begin
            r_state <= S_DISPLAY;
            r_x     <= 10'(INIT_X);
            r_y     <= 10'(INIT_Y);
            r_dx    <= 4'(STEP);
            r_dy    <= 4'(STEP);
            r_color <= SPRITE_COLOR;
            r_pend  <= 1'b0;
            r_pdx   <= 4'sd0;
            r_pdy   <= 4'sd0;
            r_pcol  <= 8'h00;
            r_tick  <= 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                r_pend <= 1'b1;
                r_pdx  <= clamp_vel(cmd_dx);
                r_pdy  <= clamp_vel(cmd_dy);
                r_pcol <= cmd_color;
            end
            case (r_state)
                S_DISPLAY: begin
                    r_tick <= 1'b0;
                    if (w_boundary) begin
                        r_state <= S_UPDATE_X;
                        r_tick  <= 1'b1;
                    end
                end
                S_UPDATE_X: begin
                    r_tick  <= 1'b0;
                    r_state <= S_UPDATE_Y;
                    if (r_pend) begin
                        r_dx    <= r_pdx;
                        r_dy    <= r_pdy;
                        r_color <= r_pcol;
                        r_pend  <= 1'b0;
                    end
                    if (run) begin
                        r_x  <= w_x_nxt;
                        r_dx <= w_dx_nxt;
                    end
                end
                S_UPDATE_Y: begin
                    r_tick  <= 1'b0;
                    r_state <= S_DISPLAY;
                    if (run) begin
                        r_y  <= w_y_nxt;
                        r_dy <= w_dy_nxt;
                    end
                end
                default: begin
                    r_tick  <= 1'b0;
                    r_state <= S_DISPLAY;
                end
            endcase
        end
    end

    assign w_hc_ext    = {1'b0, hc};
    assign w_vc_ext    = {1'b0, vc};
    assign w_x_ext     = {1'b0, r_x};
    assign w_y_ext     = {1'b0, r_y};
    assign w_in_sprite = (w_hc_ext >= w_x_ext) && (w_hc_ext < w_x_ext + 11'(SPRITE_W))
                      && (w_vc_ext >= w_y_ext) && (w_vc_ext < w_y_ext + 11'(SPRITE_H));
    assign w_pix       = w_in_sprite ? r_color : BG_COLOR;

    assign out_red    = w_pix[7:5];
    assign out_green  = w_pix[4:2];
    assign out_blue   = w_pix[1:0];
    assign frame_tick = r_tick;
    assign sprite_x   = r_x;
    assign sprite_y   = r_y;

endmodule

// File: tb/tb_bounce_sprite_gen.sv
// Self-checking bench for bounce_sprite_gen: per-frame position scoreboard
// plus direct checks of pixel colour, tick timing and the command handshake.
module tb_bounce_sprite_gen;

    logic       vgaclk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] hc = 10'd0;
    logic [9:0] vc = 10'd0;
    logic       run = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_dx = 4'd0;
    logic [3:0] cmd_dy = 4'd0;
    logic [7:0] cmd_color = 8'h00;
    logic       frame_tick;
    logic [9:0] sprite_x;
    logic [9:0] sprite_y;
    logic [2:0] out_red;
    logic [2:0] out_green;
    logic [1:0] out_blue;

    bounce_sprite_gen dut (
        .vgaclk    (vgaclk),
        .rst       (rst),
        .hc        (hc),
        .vc        (vc),
        .run       (run),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dx    (cmd_dx),
        .cmd_dy    (cmd_dy),
        .cmd_color (cmd_color),
        .frame_tick(frame_tick),
        .sprite_x  (sprite_x),
        .sprite_y  (sprite_y),
        .out_red   (out_red),
        .out_green (out_green),
        .out_blue  (out_blue)
    );

    always #20 vgaclk = ~vgaclk;

    typedef struct {
        int x;
        int y;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    // Reference model of sprite state
    int       m_x, m_y, m_dx, m_dy, m_pdx, m_pdy;
    bit       m_pend;
    logic [7:0] m_col, m_pcol;

    task automatic bstep(inout int p, inout int d, input int lim);
        int n;
        n = p + d;
        if (n < 0) begin
            p = 0;
            d = -d;
        end else if (n > lim) begin
            p = lim;
            d = -d;
        end else begin
            p = n;
        end
    endtask

    task automatic do_reset();
        @(negedge vgaclk);
        rst = 1'b1;
        cmd_valid = 1'b0;
        hc = 10'd1;
        vc = 10'd0;
        repeat (2) @(negedge vgaclk);
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_reset: got %b want 0", cmd_ready);
        end
        checks++;
        if (frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL tick_in_reset: got %b want 0", frame_tick);
        end
        rst = 1'b0;
        m_x = 100; m_y = 80; m_dx = 2; m_dy = 2; m_col = 8'hE0; m_pend = 0;
        q.delete();
        @(negedge vgaclk);
    endtask

    // One frame boundary; checks tick timing and x/y against the scoreboard.
    task automatic frame();
        exp_t e;
        if (m_pend) begin
            m_dx = m_pdx; m_dy = m_pdy; m_col = m_pcol; m_pend = 0;
        end
        if (run) begin
            bstep(m_x, m_dx, 608);
            bstep(m_y, m_dy, 448);
        end
        e.x = m_x;
        e.y = m_y;
        q.push_back(e);
        hc = 10'd0;
        vc = 10'd480;
        checks++;
        if (frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL tick_T: got %b want 0", frame_tick);
        end
        @(negedge vgaclk);
        hc = 10'd1;
        vc = 10'd0;
        checks++;
        if (frame_tick !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL upd_x_state: tick=%b ready=%b want tick=1 ready=0",
                     frame_tick, cmd_ready);
        end
        @(negedge vgaclk);
        e = q.pop_front();
        checks++;
        if (sprite_x !== 10'(e.x) || frame_tick !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL upd_y_state: x=%0d tick=%b ready=%b want x=%0d tick=0 ready=0",
                     sprite_x, frame_tick, cmd_ready, e.x);
        end
        @(negedge vgaclk);
        checks++;
        if (sprite_y !== 10'(e.y) || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_update: y=%0d ready=%b want y=%0d ready=1",
                     sprite_y, cmd_ready, e.y);
        end
    endtask

    task automatic send_cmd(input int dx, input int dy, input logic [7:0] col);
        bit done;
        done = 0;
        cmd_valid = 1'b1;
        cmd_dx = 4'(dx);
        cmd_dy = 4'(dy);
        cmd_color = col;
        for (int i = 0; i < 20 && !done; i++) begin
            if (cmd_ready === 1'b1) done = 1;
            @(negedge vgaclk);
        end
        cmd_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL cmd_accept_timeout: ready never high, want accepted");
        end
        m_pend = 1;
        m_pdx = (dx == -8) ? -7 : dx;
        m_pdy = (dy == -8) ? -7 : dy;
        m_pcol = col;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (cmd_ready !== 1'b1 || sprite_x !== 10'd100 || sprite_y !== 10'd80) begin
            errors++;
            $display("FAIL reset_state: ready=%b x=%0d y=%0d want 1/100/80",
                     cmd_ready, sprite_x, sprite_y);
        end
        hc = 10'd110; vc = 10'd90; #1;
        checks++;
        if ({out_red, out_green, out_blue} !== 8'hE0) begin
            errors++;
            $display("FAIL reset_sprite_pix: got %h want e0", {out_red, out_green, out_blue});
        end
        hc = 10'd0; vc = 10'd0; #1;
        checks++;
        if ({out_red, out_green, out_blue} !== 8'h03) begin
            errors++;
            $display("FAIL reset_bg_pix: got %h want 03", {out_red, out_green, out_blue});
        end
    endtask

    task automatic test_pixel_edges();
        int hs[4] = '{99, 100, 131, 132};
        int vs[4] = '{79, 80, 111, 112};
        logic [7:0] want;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                hc = 10'(hs[i]); vc = 10'(vs[j]); #1;
                want = (i inside {1, 2} && j inside {1, 2}) ? 8'hE0 : 8'h03;
                checks++;
                if ({out_red, out_green, out_blue} !== want) begin
                    errors++;
                    $display("FAIL pix_edge hc=%0d vc=%0d: got %h want %h",
                             hs[i], vs[j], {out_red, out_green, out_blue}, want);
                end
            end
        end
        hc = 10'd1; vc = 10'd0;
        @(negedge vgaclk);
    endtask

    task automatic test_frame_tick();
        run = 1'b1;
        frame();
        checks++;
        if (sprite_x !== 10'd102 || sprite_y !== 10'd82) begin
            errors++;
            $display("FAIL first_frame: x=%0d y=%0d want 102/82", sprite_x, sprite_y);
        end
        hc = 10'd0; vc = 10'd479;
        repeat (3) @(negedge vgaclk);
        hc = 10'd1; vc = 10'd480;
        repeat (3) @(negedge vgaclk);
        checks++;
        if (frame_tick !== 1'b0 || sprite_x !== 10'd102) begin
            errors++;
            $display("FAIL no_tick: tick=%b x=%0d want 0/102", frame_tick, sprite_x);
        end
    endtask

    task automatic test_right_bounce();
        do_reset();
        send_cmd(5, 0, 8'hE0);
        repeat (100) frame();
        checks++;
        if (sprite_x !== 10'd600) begin
            errors++;
            $display("FAIL reach_600: got %0d want 600", sprite_x);
        end
        send_cmd(7, 0, 8'hE0);
        frame();
        checks++;
        if (sprite_x !== 10'd607) begin
            errors++;
            $display("FAIL right_607: got %0d want 607", sprite_x);
        end
        frame();
        checks++;
        if (sprite_x !== 10'd608) begin
            errors++;
            $display("FAIL right_clamp_608: got %0d want 608", sprite_x);
        end
        frame();
        checks++;
        if (sprite_x !== 10'd601) begin
            errors++;
            $display("FAIL right_back_601: got %0d want 601", sprite_x);
        end
    endtask

    task automatic test_left_bounce();
        do_reset();
        send_cmd(-1, 0, 8'hE0);
        repeat (97) frame();
        checks++;
        if (sprite_x !== 10'd3) begin
            errors++;
            $display("FAIL reach_3: got %0d want 3", sprite_x);
        end
        send_cmd(-8, 0, 8'hE0);
        frame();
        checks++;
        if (sprite_x !== 10'd0) begin
            errors++;
            $display("FAIL left_clamp_0: got %0d want 0", sprite_x);
        end
        frame();
        checks++;
        if (sprite_x !== 10'd7) begin
            errors++;
            $display("FAIL left_dx_plus7: got %0d want 7", sprite_x);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_cmd(3, 1, 8'h55);
        cmd_valid = 1'b1;
        cmd_dx = 4'(-2);
        cmd_dy = 4'(-1);
        cmd_color = 8'hAA;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure: ready=%b want 0", cmd_ready);
        end
        @(negedge vgaclk);
        frame();
        // Second command is taken on the edge right after the update completes.
        @(negedge vgaclk);
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0 || sprite_x !== 10'd103 || sprite_y !== 10'd81) begin
            errors++;
            $display("FAIL first_cmd_applied: ready=%b x=%0d y=%0d want 0/103/81",
                     cmd_ready, sprite_x, sprite_y);
        end
        m_pend = 1; m_pdx = -2; m_pdy = -1; m_pcol = 8'hAA;
        frame();
        hc = 10'(m_x); vc = 10'(m_y); #1;
        checks++;
        if (sprite_x !== 10'd101 || {out_red, out_green, out_blue} !== 8'hAA) begin
            errors++;
            $display("FAIL second_cmd_applied: x=%0d pix=%h want 101/aa",
                     sprite_x, {out_red, out_green, out_blue});
        end
        hc = 10'd1; vc = 10'd0;
        @(negedge vgaclk);
    endtask

    task automatic test_reset_mid_update();
        do_reset();
        send_cmd(5, 5, 8'h1F);
        hc = 10'd0; vc = 10'd480;
        @(negedge vgaclk);
        hc = 10'd1; vc = 10'd0;
        rst = 1'b1;
        @(negedge vgaclk);
        checks++;
        if (sprite_x !== 10'd100 || frame_tick !== 1'b0 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: x=%0d tick=%b ready=%b want 100/0/0",
                     sprite_x, frame_tick, cmd_ready);
        end
        rst = 1'b0;
        m_x = 100; m_y = 80; m_dx = 2; m_dy = 2; m_col = 8'hE0; m_pend = 0;
        @(negedge vgaclk);
        frame();
        checks++;
        if (sprite_x !== 10'd102 || sprite_y !== 10'd82) begin
            errors++;
            $display("FAIL pending_dropped: x=%0d y=%0d want 102/82", sprite_x, sprite_y);
        end
    endtask

    task automatic test_run0();
        do_reset();
        run = 1'b0;
        send_cmd(3, 3, 8'h1C);
        for (int f = 0; f < 3; f++) begin
            frame();
            hc = 10'd101; vc = 10'd81; #1;
            checks++;
            if (sprite_x !== 10'd100 || sprite_y !== 10'd80 ||
                {out_red, out_green, out_blue} !== 8'h1C) begin
                errors++;
                $display("FAIL run0_frame%0d: x=%0d y=%0d pix=%h want 100/80/1c",
                         f, sprite_x, sprite_y, {out_red, out_green, out_blue});
            end
            hc = 10'd1; vc = 10'd0;
            @(negedge vgaclk);
        end
        run = 1'b1;
    endtask

    initial begin
        test_reset();
        test_pixel_edges();
        test_frame_tick();
        test_right_bounce();
        test_left_bounce();
        test_back_to_back();
        test_reset_mid_update();
        test_run0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
